// File: rtl/wishbone_arbiter_2m.sv
// Two-master, one-slave Wishbone classic arbiter with round-robin tie-break,
// per-cycle grant lock and a bus-timeout watchdog that errors the stalled owner.
module wishbone_arbiter_2m #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    input  logic                  m0_we_i,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    input  logic                  m1_we_i,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic [DATA_WIDTH-1:0] s_data_o,
    output logic                  s_we_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_ack_i,
    output logic [1:0]            grant_o
);

    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

    localparam bit                     WDOG_ON    = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_WIDTH-1:0] WDOG_LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                   fsm, fsm_next;
    logic                     owner, owner_next;
    logic                     last, last_next;
    logic [TIMEOUT_WIDTH-1:0] wdog, wdog_next;

    logic                  own_cyc, own_stb, own_we;
    logic [ADDR_WIDTH-1:0] own_addr;
    logic [DATA_WIDTH-1:0] own_data;
    logic                  slave_ack, timeout;

    assign own_cyc  = owner ? m1_cyc_i  : m0_cyc_i;
    assign own_stb  = owner ? m1_stb_i  : m0_stb_i;
    assign own_we   = owner ? m1_we_i   : m0_we_i;
    assign own_addr = owner ? m1_addr_i : m0_addr_i;
    assign own_data = owner ? m1_data_i : m0_data_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm   <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            wdog  <= '0;
        end else begin
            fsm   <= fsm_next;
            owner <= owner_next;
            last  <= last_next;
            wdog  <= wdog_next;
        end
    end

    always_comb begin
        fsm_next   = fsm;
        owner_next = owner;
        last_next  = last;
        wdog_next  = '0;
        slave_ack  = 1'b0;
        timeout    = 1'b0;
        s_addr_o   = '0;
        s_data_o   = '0;
        s_we_o     = 1'b0;
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        grant_o    = 2'b00;
        m0_data_o  = '0;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m1_data_o  = '0;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;

        case (fsm)
            IDLE: begin
                // Grant is registered: a request reaches the slave one cycle later.
                if ((m0_cyc_i && m0_stb_i) || (m1_cyc_i && m1_stb_i)) begin
                    if (m0_cyc_i && m0_stb_i && m1_cyc_i && m1_stb_i)
                        owner_next = ~last;
                    else
                        owner_next = m1_cyc_i && m1_stb_i;
                    last_next = owner_next;
                    fsm_next  = BUSY;
                end
            end
            BUSY: begin
                s_addr_o  = own_addr;
                s_data_o  = own_data;
                s_we_o    = own_we;
                s_cyc_o   = own_cyc;
                s_stb_o   = own_cyc && own_stb;
                grant_o   = owner ? 2'b10 : 2'b01;
                slave_ack = s_ack_i && own_cyc && own_stb;
                // An ack arriving on the limit cycle wins over the timeout.
                timeout   = WDOG_ON && own_cyc && own_stb && !s_ack_i && (wdog == WDOG_LIMIT);
                m0_ack_o  = !owner && slave_ack;
                m1_ack_o  = owner && slave_ack;
                m0_err_o  = !owner && timeout;
                m1_err_o  = owner && timeout;
                m0_data_o = owner ? '0 : s_data_i;
                m1_data_o = owner ? s_data_i : '0;
                if (!own_cyc)
                    fsm_next = IDLE;
                else if (timeout)
                    fsm_next = ABORT;
                else if (WDOG_ON && own_stb && !s_ack_i)
                    wdog_next = wdog + TIMEOUT_WIDTH'(1);
            end
            ABORT: begin
                grant_o = owner ? 2'b10 : 2'b01;
                if (!own_cyc)
                    fsm_next = IDLE;
            end
            default: fsm_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wishbone_arbiter_2m.sv
// Directed plus randomized bench for wishbone_arbiter_2m against a transaction-level
// model of ownership, stall counting and abort.
module tb_wishbone_arbiter_2m;

    localparam int unsigned T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cyc, stb, we;
    logic [31:0] addr [2];
    logic [63:0] wdat [2];
    logic        s_ack;
    logic [63:0] s_rdat;

    logic [63:0] m0_rdat, m1_rdat;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] s_addr;
    logic [63:0] s_wdat;
    logic        s_we, s_cyc, s_stb;
    logic [1:0]  grant;

    int checks = 0;
    int passed = 0;

    // Model: owner index (-1 = bus free), aborted flag, consecutive stalled cycles, last grantee.
    int m_owner, m_last, m_stall;
    bit m_abort;

    logic        e_scyc, e_sstb, e_swe;
    logic [31:0] e_saddr;
    logic [63:0] e_sdat;
    logic [1:0]  e_grant;
    logic        e_ack [2];
    logic        e_err [2];
    logic [63:0] e_mdat [2];

    always #5 clk = ~clk;

    wishbone_arbiter_2m #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT_CYCLES(T), .TIMEOUT_WIDTH(16)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_addr_i(addr[0]), .m0_data_i(wdat[0]), .m0_we_i(we[0]),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]),
        .m0_data_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_addr_i(addr[1]), .m1_data_i(wdat[1]), .m1_we_i(we[1]),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]),
        .m1_data_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_addr_o(s_addr), .s_data_o(s_wdat), .s_we_o(s_we),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb),
        .s_data_i(s_rdat), .s_ack_i(s_ack),
        .grant_o(grant)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
        m_stall = 0;
        m_abort = 1'b0;
    endtask

    task automatic model_eval();
        e_scyc = 1'b0; e_sstb = 1'b0; e_swe = 1'b0;
        e_saddr = '0; e_sdat = '0; e_grant = 2'b00;
        for (int m = 0; m < 2; m++) begin
            e_ack[m] = 1'b0; e_err[m] = 1'b0; e_mdat[m] = '0;
        end
        if (m_owner >= 0) begin
            e_grant = (m_owner == 1) ? 2'b10 : 2'b01;
            if (!m_abort) begin
                e_scyc         = cyc[m_owner];
                e_sstb         = cyc[m_owner] && stb[m_owner];
                e_swe          = we[m_owner];
                e_saddr        = addr[m_owner];
                e_sdat         = wdat[m_owner];
                e_mdat[m_owner] = s_rdat;
                e_ack[m_owner] = s_ack && e_sstb;
                e_err[m_owner] = (T != 0) && e_sstb && !s_ack && (m_stall == int'(T) - 1);
            end
        end
    endtask

    task automatic model_update();
        model_eval();
        if (rst) begin
            model_reset();
        end else if (m_owner < 0) begin
            if (cyc[0] && stb[0] && cyc[1] && stb[1]) m_owner = 1 - m_last;
            else if (cyc[0] && stb[0])                m_owner = 0;
            else if (cyc[1] && stb[1])                m_owner = 1;
            if (m_owner >= 0) begin
                m_last  = m_owner;
                m_stall = 0;
            end
        end else if (m_abort) begin
            if (!cyc[m_owner]) begin
                m_owner = -1;
                m_abort = 1'b0;
            end
        end else if (!cyc[m_owner]) begin
            m_owner = -1;
            m_stall = 0;
        end else if (e_err[m_owner]) begin
            m_abort = 1'b1;
            m_stall = 0;
        end else if (stb[m_owner] && !s_ack) begin
            m_stall++;
        end else begin
            m_stall = 0;
        end
    endtask

    // Called one time unit after a rising edge; checks mid-cycle, then advances one clock.
    task automatic step();
        #2;
        model_eval();
        chk("s_cyc",   64'(s_cyc),   64'(e_scyc));
        chk("s_stb",   64'(s_stb),   64'(e_sstb));
        chk("s_we",    64'(s_we),    64'(e_swe));
        chk("s_addr",  64'(s_addr),  64'(e_saddr));
        chk("s_data",  s_wdat,       e_sdat);
        chk("grant",   64'(grant),   64'(e_grant));
        chk("m0_ack",  64'(m0_ack),  64'(e_ack[0]));
        chk("m0_err",  64'(m0_err),  64'(e_err[0]));
        chk("m0_data", m0_rdat,      e_mdat[0]);
        chk("m1_ack",  64'(m1_ack),  64'(e_ack[1]));
        chk("m1_err",  64'(m1_err),  64'(e_err[1]));
        chk("m1_data", m1_rdat,      e_mdat[1]);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input int m, input logic c, input logic s, input logic w,
                         input logic [31:0] a, input logic [63:0] d);
        cyc[m]  = c;
        stb[m]  = s;
        we[m]   = w;
        addr[m] = a;
        wdat[m] = d;
    endtask

    initial begin
        cyc = '0; stb = '0; we = '0;
        addr[0] = '0; addr[1] = '0; wdat[0] = '0; wdat[1] = '0;
        s_ack = 1'b0; s_rdat = '0; rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        step();
        rst = 1'b0;

        // Single read by m0, slave acks on the third owned cycle
        drive(0, 1, 1, 0, 32'h0000_0011, '0);
        step();
        #1;
        chk("t1_grant", 64'(grant), 64'h1);
        chk("t1_scyc",  64'(s_cyc), 64'h1);
        step();
        step();
        s_ack = 1'b1; s_rdat = 64'h1234_5678_9ABC_DEF0;
        #1;
        chk("t1_ack",   64'(m0_ack), 64'h1);
        chk("t1_data",  m0_rdat,     64'h1234_5678_9ABC_DEF0);
        chk("t1_m1ack", 64'(m1_ack), 64'h0);
        step();
        s_ack = 1'b0;
        drive(0, 0, 0, 0, '0, '0);
        step();
        step();

        // Simultaneous request after reset: m0 first, then m1, then m0 again
        rst = 1'b1; step(); rst = 1'b0;
        drive(0, 1, 1, 0, 32'h20, '0);
        drive(1, 1, 1, 0, 32'h40, '0);
        step();
        #1; chk("t2_first", 64'(grant), 64'h1);
        s_ack = 1'b1; step(); s_ack = 1'b0;
        drive(0, 0, 0, 0, '0, '0);
        step();
        #1; chk("t2_gap", 64'(grant), 64'h0);
        step();
        #1; chk("t2_second", 64'(grant), 64'h2);
        s_ack = 1'b1; step(); s_ack = 1'b0;
        drive(1, 0, 0, 0, '0, '0);
        step();
        step();
        drive(0, 1, 1, 0, 32'h20, '0);
        drive(1, 1, 1, 0, 32'h40, '0);
        step();
        #1; chk("t2_rr", 64'(grant), 64'h1);
        s_ack = 1'b1; step(); s_ack = 1'b0;
        drive(0, 0, 0, 0, '0, '0);
        step();
        step();
        #1; chk("t3_m1_own", 64'(grant), 64'h2);

        // Locked burst of three writes from m1 while m0 waits
        drive(1, 1, 1, 1, 32'h80, 64'hA);
        drive(0, 1, 1, 0, 32'h90, '0);
        s_ack = 1'b1;
        step();
        drive(1, 1, 1, 1, 32'h80, 64'hB);
        #1;
        chk("t3_dataB", s_wdat, 64'hB);
        chk("t3_addr",  64'(s_addr), 64'h80);
        step();
        drive(1, 1, 1, 1, 32'h80, 64'hC);
        #1;
        chk("t3_dataC", s_wdat, 64'hC);
        chk("t3_we",    64'(s_we), 64'h1);
        chk("t3_lock",  64'(grant), 64'h2);
        step();
        s_ack = 1'b0;
        drive(1, 0, 0, 0, '0, '0);
        step();
        step();
        #1; chk("t3_m0_after", 64'(grant), 64'h1);

        // Timeout: m0 owns, slave never acks, m1 pending
        drive(1, 1, 1, 0, 32'hA0, '0);
        repeat (7) step();
        #1;
        chk("t4_err", 64'(m0_err), 64'h1);
        chk("t4_ack", 64'(m0_ack), 64'h0);
        step();
        #1;
        chk("t4_scyc",  64'(s_cyc),  64'h0);
        chk("t4_grant", 64'(grant),  64'h1);
        chk("t4_noerr", 64'(m0_err), 64'h0);
        step();
        step();
        #1; chk("t4_hold", 64'(grant), 64'h1);
        drive(0, 0, 0, 0, '0, '0);
        step();
        #1; chk("t4_idle", 64'(grant), 64'h0);
        step();
        #1; chk("t4_m1", 64'(grant), 64'h2);

        // Ack arriving on the limit cycle
        s_ack = 1'b1; step(); s_ack = 1'b0;
        drive(1, 0, 0, 0, '0, '0);
        step();
        drive(0, 1, 1, 0, 32'hB0, '0);
        step();
        repeat (7) step();
        s_ack = 1'b1; s_rdat = 64'hFEED_0000_0000_BEEF;
        #1;
        chk("t5_ack", 64'(m0_ack), 64'h1);
        chk("t5_err", 64'(m0_err), 64'h0);
        step();
        s_ack = 1'b0;
        #1;
        chk("t5_busy", 64'(grant), 64'h1);
        chk("t5_scyc", 64'(s_cyc), 64'h1);
        drive(0, 0, 0, 0, '0, '0);
        step();
        step();

        // Reset while m1 owns the bus with a strobe pending
        drive(1, 1, 1, 0, 32'hC0, '0);
        step();
        step();
        rst = 1'b1; step(); rst = 1'b0;
        #1;
        chk("t6_scyc",  64'(s_cyc),  64'h0);
        chk("t6_grant", 64'(grant),  64'h0);
        chk("t6_ack",   64'(m1_ack), 64'h0);
        chk("t6_err",   64'(m1_err), 64'h0);
        drive(0, 1, 1, 0, 32'hD0, '0);
        step();
        #1; chk("t6_m0", 64'(grant), 64'h1);
        drive(0, 0, 0, 0, '0, '0);
        drive(1, 0, 0, 0, '0, '0);
        step();
        step();
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int m = 0; m < 2; m++) begin
                if (cyc[m]) begin
                    if ($urandom_range(0, 9) == 0) begin
                        cyc[m] = 1'b0;
                        stb[m] = 1'b0;
                    end else begin
                        stb[m] = ($urandom_range(0, 3) != 0);
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    drive(m, 1'b1, 1'b1, 1'($urandom), $urandom, {$urandom, $urandom});
                end
            end
            s_rdat = {$urandom, $urandom};
            s_ack  = 1'b0;
            model_eval();
            if (e_sstb) s_ack = ($urandom_range(0, 3) == 0);
            step();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
